// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time from IDLE, inserts
// WAIT_CYCLES wait states, then completes it with a one-cycle ready pulse.
module dmem_responder #(
   parameter int DEPTH_WORDS = 64,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic        we,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        ready,
   output logic        err,
   output logic        busy
);

   localparam int unsigned AW = $clog2(DEPTH_WORDS);
   localparam int unsigned CW = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           we_q, we_d;
   logic [31:0]    addr_q, addr_d;
   logic [31:0]    wdata_q, wdata_d;
   logic [31:0]    rdata_q, rdata_d;
   logic           ready_q, ready_d;
   logic           err_q, err_d;
   logic           busy_q, busy_d;
   logic [31:0]    mem_q [DEPTH_WORDS];

   logic           go_resp_c;
   logic           mem_we_c;
   logic           cur_we_c;
   logic [31:0]    cur_addr_c;
   logic           bad_c;
   logic [AW-1:0]  cur_idx_c;

   // Request fields seen by the response logic: live inputs when the request
   // is accepted and completes in the same transition (no wait states).
   always_comb begin
      cur_we_c   = we_q;
      cur_addr_c = addr_q;
      if (state_q == IDLE) begin
         cur_we_c   = we;
         cur_addr_c = addr;
      end
      bad_c     = (cur_addr_c[1:0] != 2'b00) || (cur_addr_c[31:AW+2] != '0);
      cur_idx_c = cur_addr_c[AW+1:2];
   end

   // Next-state, latched request and registered response values.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      we_d      = we_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      rdata_d   = rdata_q;
      ready_d   = 1'b0;
      err_d     = 1'b0;
      go_resp_c = 1'b0;
      mem_we_c  = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (req) begin
               we_d    = we;
               addr_d  = addr;
               wdata_d = wdata;
               if (WAIT_CYCLES > 0) begin
                  state_d = WAIT;
                  cnt_d   = CW'(WAIT_CYCLES - 1);
               end else begin
                  go_resp_c = 1'b1;
               end
            end
         end
         WAIT: begin
            if (cnt_q == '0) go_resp_c = 1'b1;
            else             cnt_d = cnt_q - CW'(1);
         end
         RESP: begin
            state_d  = IDLE;
            mem_we_c = we_q && !err_q;
         end
         default: state_d = IDLE;
      endcase

      if (go_resp_c) begin
         state_d = RESP;
         cnt_d   = '0;
         ready_d = 1'b1;
         err_d   = bad_c;
         if (!cur_we_c && !bad_c) rdata_d = mem_q[cur_idx_c];
      end

      busy_d = (state_d != IDLE);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         ready_q <= 1'b0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         ready_q <= ready_d;
         err_q   <= err_d;
         busy_q  <= busy_d;
      end
   end

   // Store commits on the edge leaving RESP; reset on that edge cancels it.
   always_ff @(posedge clk) begin
      if (!reset && mem_we_c) mem_q[addr_q[AW+1:2]] <= wdata_q;
   end

   assign rdata = rdata_q;
   assign ready = ready_q;
   assign err   = err_q;
   assign busy  = busy_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (WAIT_CYCLES 2, 0, 3) checked
// every cycle against a transaction-level model, plus directed sequences.
module tb_dmem_responder;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_s   [3];
   logic        we_s    [3];
   logic [31:0] addr_s  [3];
   logic [31:0] wdata_s [3];
   logic [31:0] rdata_s [3];
   logic        ready_s [3];
   logic        err_s   [3];
   logic        busy_s  [3];

   int n_checks = 0;
   int n_err    = 0;
   int wcv [3]  = '{2, 0, 3};

   // model: per-instance pending request, memory image and expected outputs
   bit          m_pend  [3];
   int          m_acc   [3];
   bit          m_we    [3];
   logic [31:0] m_addr  [3];
   logic [31:0] m_wdata [3];
   logic [31:0] m_mem   [3][64];
   bit          e_ready [3];
   bit          e_err   [3];
   bit          e_busy  [3];
   logic [31:0] e_rdata [3];
   int          ecount = 0;

   typedef struct {
      bit          req;
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
      bit          ready;
      bit          err;
      bit          busy;
      logic [31:0] rdata;
   } vec_t;
   vec_t tbl [12];

   always #5 clk = ~clk;

   dmem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(2)) u0 (
      .clk(clk), .reset(reset), .req(req_s[0]), .we(we_s[0]), .addr(addr_s[0]),
      .wdata(wdata_s[0]), .rdata(rdata_s[0]), .ready(ready_s[0]), .err(err_s[0]),
      .busy(busy_s[0]));
   dmem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(0)) u1 (
      .clk(clk), .reset(reset), .req(req_s[1]), .we(we_s[1]), .addr(addr_s[1]),
      .wdata(wdata_s[1]), .rdata(rdata_s[1]), .ready(ready_s[1]), .err(err_s[1]),
      .busy(busy_s[1]));
   dmem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(3)) u2 (
      .clk(clk), .reset(reset), .req(req_s[2]), .we(we_s[2]), .addr(addr_s[2]),
      .wdata(wdata_s[2]), .rdata(rdata_s[2]), .ready(ready_s[2]), .err(err_s[2]),
      .busy(busy_s[2]));

   function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endfunction

   function automatic bit is_bad(logic [31:0] a);
      return (a[1:0] != 2'b00) || (a[31:8] != 24'h0);
   endfunction

   function automatic logic [31:0] pat(int i, int k);
      return 32'hA500_0000 ^ (32'(i) << 16) ^ 32'(k);
   endfunction

   // Transaction view: a request accepted at edge A shows ready after edge
   // A+W, finishes (store commits) at edge A+W+1, and is busy in between.
   function automatic void model_edge(int i);
      if (reset) begin
         m_pend[i]  = 1'b0;
         e_ready[i] = 1'b0;
         e_err[i]   = 1'b0;
         e_busy[i]  = 1'b0;
         e_rdata[i] = 32'h0;
         return;
      end
      if (m_pend[i] && ecount == m_acc[i] + wcv[i] + 1) begin
         if (m_we[i] && !is_bad(m_addr[i])) m_mem[i][m_addr[i][7:2]] = m_wdata[i];
         m_pend[i] = 1'b0;
      end else if (!m_pend[i] && req_s[i]) begin
         m_pend[i]  = 1'b1;
         m_acc[i]   = ecount;
         m_we[i]    = we_s[i];
         m_addr[i]  = addr_s[i];
         m_wdata[i] = wdata_s[i];
      end
      e_busy[i]  = m_pend[i];
      e_ready[i] = m_pend[i] && (ecount == m_acc[i] + wcv[i]);
      e_err[i]   = e_ready[i] && is_bad(m_addr[i]);
      if (e_ready[i] && !m_we[i] && !is_bad(m_addr[i]))
         e_rdata[i] = m_mem[i][m_addr[i][7:2]];
   endfunction

   task automatic tick();
      @(posedge clk);
      for (int i = 0; i < 3; i++) model_edge(i);
      ecount++;
      #1;
      for (int i = 0; i < 3; i++) begin
         check($sformatf("u%0d ready", i), 32'(ready_s[i]), 32'(e_ready[i]));
         check($sformatf("u%0d err", i),   32'(err_s[i]),   32'(e_err[i]));
         check($sformatf("u%0d busy", i),  32'(busy_s[i]),  32'(e_busy[i]));
         check($sformatf("u%0d rdata", i), rdata_s[i],      e_rdata[i]);
      end
   endtask

   task automatic xact(input int i, input bit w, input logic [31:0] a,
                       input logic [31:0] d, input bit scramble,
                       output bit e, output logic [31:0] rd);
      int lat;
      req_s[i] = 1'b1; we_s[i] = w; addr_s[i] = a; wdata_s[i] = d;
      tick();
      req_s[i] = 1'b0;
      if (scramble) begin
         addr_s[i] = $urandom; wdata_s[i] = $urandom; we_s[i] = ~w;
      end
      lat = 1;
      while (ready_s[i] !== 1'b1 && lat < 20) begin
         tick();
         lat++;
      end
      check($sformatf("u%0d latency", i), 32'(lat), 32'(wcv[i] + 1));
      e  = err_s[i];
      rd = rdata_s[i];
      tick();
      addr_s[i] = 32'h0; wdata_s[i] = 32'h0; we_s[i] = 1'b0;
   endtask

   initial begin
      bit          e;
      logic [31:0] rd;
      int          nrdy;
      int          pos [$];

      tbl[0]  = '{1, 1, 32'h10, 32'hDEADBEEF, 0, 0, 1, 32'h0};
      tbl[1]  = '{0, 0, 32'h0,  32'h0,        0, 0, 1, 32'h0};
      tbl[2]  = '{0, 0, 32'h0,  32'h0,        1, 0, 1, 32'h0};
      tbl[3]  = '{1, 0, 32'h10, 32'h0,        0, 0, 0, 32'h0};
      tbl[4]  = '{1, 0, 32'h10, 32'h0,        0, 0, 1, 32'h0};
      tbl[5]  = '{0, 0, 32'h0,  32'h0,        0, 0, 1, 32'h0};
      tbl[6]  = '{0, 0, 32'h0,  32'h0,        1, 0, 1, 32'hDEADBEEF};
      tbl[7]  = '{0, 0, 32'h0,  32'h0,        0, 0, 0, 32'hDEADBEEF};
      tbl[8]  = '{1, 0, 32'h13, 32'h0,        0, 0, 1, 32'hDEADBEEF};
      tbl[9]  = '{0, 0, 32'h0,  32'h0,        0, 0, 1, 32'hDEADBEEF};
      tbl[10] = '{0, 0, 32'h0,  32'h0,        1, 1, 1, 32'hDEADBEEF};
      tbl[11] = '{0, 0, 32'h0,  32'h0,        0, 0, 0, 32'hDEADBEEF};

      for (int i = 0; i < 3; i++) begin
         req_s[i] = 1'b0; we_s[i] = 1'b0; addr_s[i] = 32'h0; wdata_s[i] = 32'h0;
         m_pend[i] = 1'b0; e_rdata[i] = 32'h0;
      end

      reset = 1'b1;
      repeat (2) tick();
      reset = 1'b0;

      // preload every word of every instance with a known pattern
      for (int k = 0; k < 64; k++) begin
         for (int i = 0; i < 3; i++) begin
            req_s[i] = 1'b1; we_s[i] = 1'b1; addr_s[i] = 32'(k * 4); wdata_s[i] = pat(i, k);
         end
         tick();
         for (int i = 0; i < 3; i++) req_s[i] = 1'b0;
         repeat (5) tick();
      end

      reset = 1'b1;
      tick();
      reset = 1'b0;

      // store/load/misaligned sequence on the 2-wait-state instance
      for (int r = 0; r < 12; r++) begin
         req_s[0] = tbl[r].req; we_s[0] = tbl[r].we;
         addr_s[0] = tbl[r].addr; wdata_s[0] = tbl[r].wdata;
         tick();
         check($sformatf("tbl%0d ready", r), 32'(ready_s[0]), 32'(tbl[r].ready));
         check($sformatf("tbl%0d err", r),   32'(err_s[0]),   32'(tbl[r].err));
         check($sformatf("tbl%0d busy", r),  32'(busy_s[0]),  32'(tbl[r].busy));
         check($sformatf("tbl%0d rdata", r), rdata_s[0],      tbl[r].rdata);
      end
      req_s[0] = 1'b0;

      // zero wait states: back-to-back requests every cycle
      nrdy = 0;
      for (int j = 0; j < 16; j++) begin
         req_s[1] = 1'b1; we_s[1] = ((j % 4) < 2); addr_s[1] = 32'h40;
         wdata_s[1] = 32'hC0DE_0000 + 32'(j);
         tick();
         check($sformatf("w0 ready c%0d", j), 32'(ready_s[1]), 32'(j % 2 == 0));
         check($sformatf("w0 busy c%0d", j),  32'(busy_s[1]),  32'(j % 2 == 0));
         if (ready_s[1] === 1'b1) nrdy++;
      end
      req_s[1] = 1'b0;
      tick();
      check("w0 response count", 32'(nrdy), 32'd8);

      // out-of-range store leaves memory alone and rdata unchanged
      xact(0, 1'b1, 32'h100, 32'h1234_5678, 1'b0, e, rd);
      check("oor err", 32'(e), 32'd1);
      check("oor rdata held", rd, 32'hDEADBEEF);
      xact(0, 1'b0, 32'h0, 32'h0, 1'b0, e, rd);
      check("load 0 err", 32'(e), 32'd0);
      check("load 0 data", rd, pat(0, 0));

      // inputs changing while waiting do not disturb the latched request
      xact(0, 1'b1, 32'h30, 32'hCAFE_F00D, 1'b1, e, rd);
      check("scramble store err", 32'(e), 32'd0);
      xact(0, 1'b0, 32'h30, 32'h0, 1'b1, e, rd);
      check("scramble load data", rd, 32'hCAFE_F00D);

      // reset in WAIT aborts a pending store
      xact(0, 1'b1, 32'h20, 32'h1, 1'b0, e, rd);
      req_s[0] = 1'b1; we_s[0] = 1'b1; addr_s[0] = 32'h20; wdata_s[0] = 32'h99;
      tick();
      req_s[0] = 1'b0;
      reset = 1'b1;
      tick();
      check("abort busy", 32'(busy_s[0]), 32'd0);
      reset = 1'b0;
      for (int j = 0; j < 4; j++) begin
         tick();
         check("abort no ready", 32'(ready_s[0]), 32'd0);
      end
      xact(0, 1'b0, 32'h20, 32'h0, 1'b0, e, rd);
      check("abort old data", rd, 32'h1);

      // req during reset is not accepted
      req_s[0] = 1'b1; we_s[0] = 1'b0; addr_s[0] = 32'h20;
      reset = 1'b1;
      tick();
      reset = 1'b0; req_s[0] = 1'b0;
      tick();
      check("req in reset ignored", 32'(busy_s[0]), 32'd0);

      // req held high for 20 cycles with 3 wait states
      req_s[2] = 1'b1; we_s[2] = 1'b0; addr_s[2] = 32'h8;
      for (int j = 0; j < 20; j++) begin
         tick();
         if (ready_s[2] === 1'b1) pos.push_back(j);
      end
      req_s[2] = 1'b0;
      repeat (5) tick();
      check("held req responses", 32'(pos.size()), 32'd4);
      if (pos.size() > 0) check("held req first ready", 32'(pos[0]), 32'd3);
      for (int k = 1; k < pos.size(); k++)
         check("held req spacing", 32'(pos[k] - pos[k-1]), 32'd5);

      // randomized traffic against the model
      for (int c = 0; c < 800; c++) begin
         reset = ($urandom_range(0, 49) == 0);
         for (int i = 0; i < 3; i++) begin
            int sel;
            sel = $urandom_range(0, 9);
            req_s[i]   = $urandom_range(0, 1) == 1;
            we_s[i]    = $urandom_range(0, 1) == 1;
            wdata_s[i] = $urandom;
            if (sel < 7)       addr_s[i] = 32'($urandom_range(0, 63)) << 2;
            else if (sel == 7) addr_s[i] = (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(1, 3));
            else if (sel == 8) addr_s[i] = 32'h100 + (32'($urandom_range(0, 63)) << 2);
            else               addr_s[i] = $urandom;
         end
         tick();
      end
      reset = 1'b0;
      for (int i = 0; i < 3; i++) req_s[i] = 1'b0;
      repeat (6) tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
